// File: rtl/imem_loader.sv
// UART boot loader: receives an 8N1 framed image (A5, LEN_LO, LEN_HI, LEN words LSB-first)
// and writes it word by word into instruction memory, holding the core in reset until done.
module imem_loader #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter logic [31:0] BASE_ADDR    = 32'h0100_0000,
  parameter int unsigned MAX_WORDS    = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        uart_rx,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        core_hold,
  output logic        done,
  output logic        error,
  output logic [15:0] words_loaded
);

  localparam int unsigned        CNT_W     = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]   FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]   HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {S_SYNC, S_LEN_LO, S_LEN_HI, S_DATA, S_DONE, S_ERROR} state_t;

  // receiver
  logic             r_rx_meta, r_rx_sync, r_rx_prev;
  rx_state_t        r_rx_state, w_rx_next;
  logic [CNT_W-1:0] r_rx_cnt;
  logic [2:0]       r_rx_bit;
  logic [7:0]       r_rx_shift;
  logic             w_rx_tick;
  logic             w_byte_valid, w_frame_err;
  logic [7:0]       w_rx_byte;

  // loader
  state_t      r_state, w_next;
  logic [7:0]  r_len_lo;
  logic [15:0] r_len;
  logic [1:0]  r_idx;
  logic [23:0] r_word;
  logic [31:0] r_wdata;
  logic        r_we;
  logic [15:0] r_words;
  logic [15:0] w_len;
  logic        w_last;

  always_comb begin
    w_rx_next = r_rx_state;
    w_rx_tick = 1'b0;
    case (r_rx_state)
      RX_IDLE: begin
        if (r_rx_prev && !r_rx_sync) w_rx_next = RX_START;
      end
      RX_START: begin
        // mid-start-bit re-sample rejects glitches
        w_rx_tick = (r_rx_cnt == HALF_LAST);
        if (w_rx_tick) w_rx_next = r_rx_sync ? RX_IDLE : RX_DATA;
      end
      RX_DATA: begin
        w_rx_tick = (r_rx_cnt == FULL_LAST);
        if (w_rx_tick && (r_rx_bit == 3'd7)) w_rx_next = RX_STOP;
      end
      RX_STOP: begin
        w_rx_tick = (r_rx_cnt == FULL_LAST);
        if (w_rx_tick) w_rx_next = RX_IDLE;
      end
      default: w_rx_next = RX_IDLE;
    endcase
  end

  assign w_byte_valid = (r_rx_state == RX_STOP) && w_rx_tick && r_rx_sync;
  assign w_frame_err  = (r_rx_state == RX_STOP) && w_rx_tick && !r_rx_sync;
  assign w_rx_byte    = r_rx_shift;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_meta  <= 1'b1;
      r_rx_sync  <= 1'b1;
      r_rx_prev  <= 1'b1;
      r_rx_state <= RX_IDLE;
      r_rx_cnt   <= '0;
      r_rx_bit   <= '0;
      r_rx_shift <= '0;
    end else begin
      r_rx_meta  <= uart_rx;
      r_rx_sync  <= r_rx_meta;
      r_rx_prev  <= r_rx_sync;
      r_rx_state <= w_rx_next;
      r_rx_cnt   <= (r_rx_state == RX_IDLE || w_rx_tick) ? '0 : r_rx_cnt + 1'b1;
      if (r_rx_state == RX_START) r_rx_bit <= '0;
      if (r_rx_state == RX_DATA && w_rx_tick) begin
        r_rx_shift <= {r_rx_sync, r_rx_shift[7:1]};
        r_rx_bit   <= r_rx_bit + 1'b1;
      end
    end
  end

  assign w_len  = {w_rx_byte, r_len_lo};
  assign w_last = ((r_words + 16'd1) == r_len);

  always_comb begin
    w_next = r_state;
    if (w_frame_err && r_state != S_DONE) begin
      w_next = S_ERROR;
    end else begin
      case (r_state)
        S_SYNC:   if (w_byte_valid && w_rx_byte == 8'hA5) w_next = S_LEN_LO;
        S_LEN_LO: if (w_byte_valid) w_next = S_LEN_HI;
        S_LEN_HI: begin
          if (w_byte_valid) begin
            if (w_len == 16'd0)                 w_next = S_DONE;
            else if (32'(w_len) > MAX_WORDS)    w_next = S_ERROR;
            else                                w_next = S_DATA;
          end
        end
        S_DATA:   if (r_we && w_last) w_next = S_DONE;
        default:  w_next = r_state;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_SYNC;
      r_len_lo <= '0;
      r_len    <= '0;
      r_idx    <= '0;
      r_word   <= '0;
      r_wdata  <= '0;
      r_we     <= 1'b0;
      r_words  <= '0;
    end else begin
      r_state <= w_next;
      r_we    <= (r_state == S_DATA) && w_byte_valid && (r_idx == 2'd3);
      if (r_we) r_words <= r_words + 16'd1;
      if (r_state == S_LEN_LO && w_byte_valid) r_len_lo <= w_rx_byte;
      if (r_state == S_LEN_HI && w_byte_valid) begin
        r_len <= w_len;
        r_idx <= '0;
      end
      if (r_state == S_DATA && w_byte_valid) begin
        r_idx <= r_idx + 2'd1;
        case (r_idx)
          2'd0:    r_word[7:0]   <= w_rx_byte;
          2'd1:    r_word[15:8]  <= w_rx_byte;
          2'd2:    r_word[23:16] <= w_rx_byte;
          default: r_wdata       <= {w_rx_byte, r_word};
        endcase
      end
    end
  end

  assign imem_we      = r_we;
  assign imem_addr    = BASE_ADDR + {14'd0, r_words, 2'b00};
  assign imem_wdata   = r_wdata;
  assign core_hold    = (r_state != S_DONE);
  assign done         = (r_state == S_DONE);
  assign error        = (r_state == S_ERROR);
  assign words_loaded = r_words;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: serial frames in, expected writes queued and checked on imem_we.
module tb_imem_loader;

  localparam int unsigned CPB  = 4;
  localparam logic [31:0] BASE = 32'h0100_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        uart_rx;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        core_hold;
  logic        done;
  logic        error;
  logic [15:0] words_loaded;

  imem_loader #(
    .CLKS_PER_BIT (CPB),
    .BASE_ADDR    (BASE),
    .MAX_WORDS    (1024)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .uart_rx      (uart_rx),
    .imem_we      (imem_we),
    .imem_addr    (imem_addr),
    .imem_wdata   (imem_wdata),
    .core_hold    (core_hold),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    bit          last;
    int unsigned n;
  } wr_t;

  wr_t sb[$];
  int  checks = 0;
  int  errors = 0;
  bit  done_pending = 1'b0;
  int unsigned exp_words = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // write monitor: every imem_we must match the head of the scoreboard
  always @(negedge clk) begin
    wr_t e;
    if (done_pending) begin
      done_pending = 1'b0;
      chk("done_after_last_we", 32'(done), 32'd1);
      chk("hold_after_last_we", 32'(core_hold), 32'd0);
      chk("words_after_last_we", 32'(words_loaded), 32'(exp_words));
    end
    if (imem_we === 1'b1 && rst === 1'b0) begin
      if (sb.size() == 0) begin
        chk("unexpected_we", 32'(imem_we), 32'd0);
      end else begin
        e = sb.pop_front();
        chk("we_addr", imem_addr, e.addr);
        chk("we_data", imem_wdata, e.data);
        chk("we_hold", 32'(core_hold), 32'd1);
        if (e.last) begin
          done_pending = 1'b1;
          exp_words    = e.n;
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit stop_ok = 1'b1);
    uart_rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    uart_rx = stop_ok;
    repeat (CPB) @(negedge clk);
    uart_rx = 1'b1;
  endtask

  task automatic do_reset(input int unsigned n);
    rst = 1'b1;
    repeat (n) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] d, input bit last, input int unsigned n);
    wr_t e;
    e.addr = a; e.data = d; e.last = last; e.n = n;
    sb.push_back(e);
  endtask

  task automatic send_normal();
    logic [7:0] f [11];
    f = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    push(BASE, 32'h0000_0013, 1'b0, 1);
    push(BASE + 32'd4, 32'h0010_0093, 1'b1, 2);
    for (int i = 0; i < 11; i++) send_byte(f[i]);
  endtask

  initial begin
    rst     = 1'b1;
    uart_rx = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_we", 32'(imem_we), 32'd0);
    chk("rst_addr", imem_addr, BASE);
    chk("rst_wdata", imem_wdata, 32'd0);
    chk("rst_hold", 32'(core_hold), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_words", 32'(words_loaded), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // normal load at full line rate
    send_normal();
    repeat (6) @(negedge clk);
    chk("norm_done", 32'(done), 32'd1);
    chk("norm_hold", 32'(core_hold), 32'd0);
    chk("norm_words", 32'(words_loaded), 32'd2);
    chk("norm_addr", imem_addr, BASE + 32'd8);
    chk("norm_wdata_hold", imem_wdata, 32'h0010_0093);
    chk("norm_drain", 32'(sb.size()), 32'd0);
    send_byte(8'hA5);
    repeat (4) @(negedge clk);
    chk("norm_done_sticky", 32'(done), 32'd1);

    // leading junk
    do_reset(2);
    send_byte(8'h00);
    send_byte(8'hFF);
    send_byte(8'h5A);
    send_normal();
    repeat (6) @(negedge clk);
    chk("junk_done", 32'(done), 32'd1);
    chk("junk_words", 32'(words_loaded), 32'd2);
    chk("junk_drain", 32'(sb.size()), 32'd0);

    // empty image
    do_reset(2);
    send_byte(8'hA5);
    send_byte(8'h00);
    chk("empty_done_early", 32'(done), 32'd0);
    chk("empty_hold_early", 32'(core_hold), 32'd1);
    send_byte(8'h00);
    repeat (3) @(negedge clk);
    chk("empty_done", 32'(done), 32'd1);
    chk("empty_hold", 32'(core_hold), 32'd0);
    chk("empty_words", 32'(words_loaded), 32'd0);
    chk("empty_error", 32'(error), 32'd0);

    // bad length 1025
    do_reset(2);
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h04);
    repeat (3) @(negedge clk);
    chk("badlen_error", 32'(error), 32'd1);
    chk("badlen_hold", 32'(core_hold), 32'd1);
    chk("badlen_done", 32'(done), 32'd0);
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    send_byte(8'h44);
    repeat (4) @(negedge clk);
    chk("badlen_error_sticky", 32'(error), 32'd1);
    chk("badlen_words", 32'(words_loaded), 32'd0);
    chk("badlen_done_late", 32'(done), 32'd0);

    // framing error mid-word
    do_reset(2);
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'hAA);
    send_byte(8'h55, 1'b0);
    repeat (4) @(negedge clk);
    chk("frame_error", 32'(error), 32'd1);
    chk("frame_words", 32'(words_loaded), 32'd0);
    chk("frame_hold", 32'(core_hold), 32'd1);
    chk("frame_done", 32'(done), 32'd0);

    // reset in the middle of a word
    do_reset(2);
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h11);
    send_byte(8'h22);
    do_reset(1);
    chk("midrst_words", 32'(words_loaded), 32'd0);
    chk("midrst_hold", 32'(core_hold), 32'd1);
    chk("midrst_wdata", imem_wdata, 32'd0);
    chk("midrst_error", 32'(error), 32'd0);
    push(BASE, 32'h1122_3344, 1'b1, 1);
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h44);
    send_byte(8'h33);
    chk("midrst_hold_loading", 32'(core_hold), 32'd1);
    send_byte(8'h22);
    send_byte(8'h11);
    repeat (6) @(negedge clk);
    chk("midrst_done", 32'(done), 32'd1);
    chk("midrst_words_final", 32'(words_loaded), 32'd1);
    chk("midrst_drain", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
